// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter signal bundle for uart_tx_arbiter.
// The slave side is the arbiter; the master side is the requesters plus the UART transmitter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic                          txReady;
  logic                          txByteStart;
  logic [DATA_WIDTH-1:0]         byteForTx;
  logic                          busy;
  logic [ID_W-1:0]               grant_id;

  modport slave (
    input  req, req_data, txReady,
    output ack, txByteStart, byteForTx, busy, grant_id
  );

  modport master (
    output req, req_data, txReady,
    input  ack, txByteStart, byteForTx, busy, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ requesters.
// Each grant sends a header byte (HDR_BASE + id) followed by the requester's data byte.
module uart_tx_arbiter #(
  parameter int                    NUM_REQ    = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] HDR_BASE   = 8'hF0
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_ACCEPT,
    ST_WAIT_DONE,
    ST_ACK
  } state_e;

  localparam logic PH_HDR  = 1'b0;
  localparam logic PH_DATA = 1'b1;

  state_e                 state_q;
  logic                   phase_q;
  logic [ID_W-1:0]        ptr_q;
  logic [ID_W-1:0]        grant_id_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [DATA_WIDTH-1:0]  byte_q;
  logic [NUM_REQ-1:0]     ack_q;

  logic [NUM_REQ-1:0]     rot_req;
  logic [DATA_WIDTH-1:0]  req_byte [NUM_REQ];
  logic [ID_W:0]          pick_ofs;
  logic [ID_W-1:0]        pick_id;
  logic [ID_W-1:0]        ptr_d;

  // Modular add of two values below NUM_REQ; one conditional subtract suffices.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input logic [ID_W:0] b);
    logic [ID_W:0] s;
    s = {1'b0, a} + b;
    if (s >= (ID_W+1)'(NUM_REQ)) begin
      s = s - (ID_W+1)'(NUM_REQ);
    end
    return s[ID_W-1:0];
  endfunction

  // Requests rotated so that bit 0 is the requester the pointer currently favours.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign rot_req[gi]  = bus.req[wrap_add(ptr_q, (ID_W+1)'(gi))];
      assign req_byte[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    pick_ofs = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        pick_ofs = (ID_W+1)'(i);
      end
    end
  end

  assign pick_id = wrap_add(ptr_q, pick_ofs);
  assign ptr_d   = wrap_add(grant_id_q, (ID_W+1)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_HDR;
      ptr_q      <= '0;
      grant_id_q <= '0;
      data_q     <= '0;
      byte_q     <= '0;
      ack_q      <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|bus.req) begin
            grant_id_q <= pick_id;
            data_q     <= req_byte[pick_id];
            byte_q     <= HDR_BASE + DATA_WIDTH'(pick_id);
            phase_q    <= PH_HDR;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (bus.txReady) begin
            state_q <= ST_WAIT_ACCEPT;
          end
        end
        ST_WAIT_ACCEPT: begin
          if (!bus.txReady) begin
            state_q <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (bus.txReady) begin
            if (phase_q == PH_HDR) begin
              phase_q <= PH_DATA;
              byte_q  <= data_q;
              state_q <= ST_START;
            end else begin
              ack_q   <= NUM_REQ'(1) << grant_id_q;
              state_q <= ST_ACK;
            end
          end
        end
        ST_ACK: begin
          ptr_q   <= ptr_d;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack         = ack_q;
  assign bus.txByteStart = (state_q == ST_START) && bus.txReady;
  assign bus.byteForTx   = byte_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.grant_id    = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter with a behavioural UART transmitter model.
module tb_uart_tx_arbiter;
  localparam int         N  = 4;
  localparam int         DW = 8;
  localparam logic [7:0] HB = 8'hF0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .HDR_BASE(HB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         id;
    logic [7:0] hdr;
    logic [7:0] data;
  } exp_t;

  int         checks = 0;
  int         fails  = 0;
  exp_t       exp_q[$];
  logic [7:0] got_q[$];
  int         ack_log[$];
  int         ack_total = 0;
  int         start_total = 0;
  int         tx_cnt = 0;
  bit         tx_pend = 1'b0;
  bit         tx_hold = 1'b0;
  int         mptr = 0;
  bit         grant_prev = 1'b0;
  bit         ack_prev = 1'b0;
  logic [7:0] last_hdr = '0;
  logic [7:0] last_data = '0;
  bit [N-1:0] rearm = '0;
  exp_t       e;
  int         aid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req_v, $time);
    end
  endtask

  // Transmitter model plus monitor/scoreboard; outputs are sampled 1 time unit after the negedge.
  always @(negedge clk) begin
    if (tx_cnt > 0) tx_cnt--;
    if (tx_pend) begin
      tx_cnt  = 20;
      tx_pend = 1'b0;
    end
    bus.txReady = (tx_cnt == 0) && !tx_hold;
    #1;
    if (ack_prev) begin
      check("busy_after_ack", 32'(bus.busy), 0);
      check("ack_one_cycle", 32'(bus.ack), 0);
      ack_prev = 1'b0;
    end
    if (grant_prev) begin
      check("grant_busy", 32'(bus.busy), 1);
      check("start_latency", 32'(bus.txByteStart), 32'(bus.txReady));
      check("hdr_on_bus", 32'(bus.byteForTx), 32'(exp_q[$].hdr));
      grant_prev = 1'b0;
    end
    if (bus.txByteStart) begin
      check("start_tx_idle", 32'((tx_cnt == 0) && !tx_pend && bus.txReady), 1);
      got_q.push_back(bus.byteForTx);
      start_total++;
      tx_pend = 1'b1;
    end
    if (bus.ack != '0) begin
      ack_total++;
      ack_prev = 1'b1;
      aid = -1;
      for (int i = 0; i < N; i++) if (bus.ack[i]) aid = i;
      if (exp_q.size() == 0) begin
        check("ack_expected", 32'(bus.ack), 0);
      end else begin
        e = exp_q.pop_front();
        check("ack_vector", 32'(bus.ack), 32'(1) << e.id);
        check("grant_id", 32'(bus.grant_id), 32'(e.id));
        check("byte_count", 32'(got_q.size()), 2);
        if (got_q.size() == 2) begin
          check("hdr_byte", 32'(got_q[0]), 32'(e.hdr));
          check("data_byte", 32'(got_q[1]), 32'(e.data));
          last_hdr  = got_q[0];
          last_data = got_q[1];
        end
      end
      ack_log.push_back(aid);
      $display("ack id=%0d hdr=%02h data=%02h", aid, last_hdr, last_data);
      got_q.delete();
    end
    // Reference arbitration: first pending requester at or after the pointer, cyclically.
    if (rst) begin
      exp_q.delete();
      got_q.delete();
      mptr       = 0;
      grant_prev = 1'b0;
      ack_prev   = 1'b0;
    end else if (!bus.busy && bus.req != '0) begin
      for (int off = 0; off < N; off++) begin
        int id;
        id = (mptr + off) % N;
        if (bus.req[id]) begin
          e.id   = id;
          e.hdr  = 8'(HB + 8'(id));
          e.data = bus.req_data[id*DW +: DW];
          exp_q.push_back(e);
          mptr       = (id + 1) % N;
          grant_prev = 1'b1;
          break;
        end
      end
    end
  end

  // Advance one cycle; requesters drop their request on ack unless re-arming.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (bus.ack[i]) begin
        if (rearm[i]) bus.req_data[i*DW +: DW] = 8'($urandom);
        else          bus.req[i] = 1'b0;
      end
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] d);
    bus.req_data[i*DW +: DW] = d;
    bus.req[i] = 1'b1;
  endtask

  task automatic wait_acks(input int n, input string name);
    int target;
    int cyc;
    target = ack_total + n;
    cyc = 0;
    while (ack_total < target && cyc < 400 * n) begin
      step();
      cyc++;
    end
    check({name, "_timeout"}, 32'(ack_total >= target), 1);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((bus.req != '0 || bus.busy) && cyc < 3000) begin
      step();
      cyc++;
    end
    check("drain_timeout", 32'(bus.req == '0 && !bus.busy), 1);
  endtask

  task automatic wait_starts(input int target, input string name);
    int cyc;
    cyc = 0;
    while (start_total < target && cyc < 300) begin
      step();
      cyc++;
    end
    check({name, "_timeout"}, 32'(start_total >= target), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int sz;
    bus.req      = '0;
    bus.req_data = '0;
    rst          = 1'b1;
    repeat (3) step();
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_start", 32'(bus.txByteStart), 0);
    check("rst_byte", 32'(bus.byteForTx), 0);
    check("rst_grant_id", 32'(bus.grant_id), 0);
    rst = 1'b0;
    step();

    // Single request.
    set_req(2, 8'h5A);
    wait_acks(1, "single");
    check("single_id", 32'(ack_log[$]), 2);
    check("single_hdr", 32'(last_hdr), 32'h F2);
    check("single_data", 32'(last_data), 32'h5A);
    repeat (2) step();

    // All four requests held from reset, then again.
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 8'($urandom));
    step();
    rst = 1'b0;
    wait_acks(4, "all4_a");
    sz = ack_log.size();
    for (int k = 0; k < 4; k++) check("all4_a_order", 32'(ack_log[sz-4+k]), 32'(k));
    for (int i = 0; i < N; i++) set_req(i, 8'($urandom));
    wait_acks(4, "all4_b");
    sz = ack_log.size();
    for (int k = 0; k < 4; k++) check("all4_b_order", 32'(ack_log[sz-4+k]), 32'(k));
    repeat (2) step();

    // Fairness between a re-arming requester 0 and a held requester 2.
    rearm = 4'b0101;
    set_req(0, 8'($urandom));
    set_req(2, 8'($urandom));
    wait_acks(8, "fair");
    sz = ack_log.size();
    for (int k = 0; k < 8; k++) check("fair_order", 32'(ack_log[sz-8+k]), (k % 2 == 0) ? 0 : 2);
    rearm = '0;
    drain();

    // Transmitter busy when the grant happens.
    tx_hold = 1'b1;
    step();
    s0 = start_total;
    set_req(1, 8'($urandom));
    repeat (50) step();
    check("busy_tx_no_start", 32'(start_total), 32'(s0));
    check("busy_tx_busy", 32'(bus.busy), 1);
    check("busy_tx_hdr", 32'(bus.byteForTx), 32'hF1);
    tx_hold = 1'b0;
    step();
    check("busy_tx_one_pulse", 32'(start_total), 32'(s0 + 1));
    wait_acks(1, "busy_tx");
    check("busy_tx_starts", 32'(start_total), 32'(s0 + 2));
    repeat (2) step();

    // Request and data withdrawn during the header byte.
    s0 = start_total;
    set_req(1, 8'hC3);
    wait_starts(s0 + 1, "withdraw_start");
    step();
    bus.req[1] = 1'b0;
    bus.req_data[1*DW +: DW] = 8'h00;
    wait_acks(1, "withdraw");
    check("withdraw_id", 32'(ack_log[$]), 1);
    check("withdraw_data", 32'(last_data), 32'hC3);
    repeat (2) step();

    // Reset during the data-byte transmission.
    s0 = start_total;
    sz = ack_total;
    set_req(2, 8'($urandom));
    wait_starts(s0 + 2, "rstmid_start");
    step();
    step();
    check("rstmid_in_wait_done", 32'(bus.txReady), 0);
    rst = 1'b1;
    step();
    check("rstmid_busy", 32'(bus.busy), 0);
    check("rstmid_ack", 32'(bus.ack), 0);
    check("rstmid_grant_id", 32'(bus.grant_id), 0);
    check("rstmid_no_ack", 32'(ack_total), 32'(sz));
    rst = 1'b0;
    bus.req = '0;
    set_req(1, 8'($urandom));
    set_req(2, 8'($urandom));
    wait_acks(2, "rstmid_ptr");
    sz = ack_log.size();
    check("rstmid_first", 32'(ack_log[sz-2]), 1);
    check("rstmid_second", 32'(ack_log[sz-1]), 2);
    set_req(3, 8'($urandom));
    wait_acks(1, "rstmid_f3");
    check("rstmid_f3_hdr", 32'(last_hdr), 32'hF3);
    repeat (2) step();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      step();
      if ($urandom_range(0, 3) == 0) begin
        int i;
        i = $urandom_range(0, N - 1);
        if (!bus.req[i]) set_req(i, 8'($urandom));
      end
    end
    drain();
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter of `uart_system` between `NUM_REQ` requesters (processor cores, debug unit). Each granted transfer is framed as two UART bytes: a header carrying the requester ID, then the requester's data byte. The block drives `txByteStart`/`byteForTx` and observes `txReady`. Requesters see only a level request and a one-cycle completion acknowledge.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `DATA_WIDTH`, default 8: UART byte width.
- `HDR_BASE`, default 8'hF0: header byte value is `HDR_BASE + id`, truncated to `DATA_WIDTH`.

- `clk`  in  1: system clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  NUM_REQ: level request per requester; held until its `ack`.
- `req_data`  in  NUM_REQ*DATA_WIDTH: requester i's byte at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `ack`  out  NUM_REQ: one-cycle pulse on the granted bit when its data byte has fully transmitted.
- `txReady`  in  1: transmitter idle, from `uart_system`.
- `txByteStart`  out  1: start pulse to the transmitter.
- `byteForTx`  out  DATA_WIDTH: byte to the transmitter.
- `busy`  out  1: high in every state except IDLE.
- `grant_id`  out  clog2(NUM_REQ): ID of the current or last granted requester.

## Operation
- States: IDLE, START, WAIT_ACCEPT, WAIT_DONE, ACK. A `phase` bit selects HDR (0) or DATA (1).
- **IDLE**
  - If `req` != 0, pick the first set bit at or after `ptr`, searching cyclically upward with wrap.
  - Latch its ID into `grant_id` and its `req_data` slice into an internal data register.
  - Set `phase`=HDR and go to START.
  - If `req` == 0, stay in IDLE.
- **START**
  - `byteForTx` = header (`HDR_BASE + grant_id`) when phase=HDR, else the latched data.
  - `txByteStart` = `txReady`, combinational, only in this state.
  - If `txReady`=1, go to WAIT_ACCEPT. Otherwise stay in START with no pulse.
- **WAIT_ACCEPT**: stay until `txReady`=0, then go to WAIT_DONE.
- **WAIT_DONE**: stay until `txReady`=1.
  - If phase=HDR: set phase=DATA and go to START.
  - If phase=DATA: go to ACK.
- **ACK**
  - `ack[grant_id]`=1 for exactly this cycle.
  - Set `ptr` = `grant_id`+1, wrapping to 0 past NUM_REQ-1.
  - Go to IDLE.
- `byteForTx` holds its value from START through WAIT_DONE. It is don't-care-stable in IDLE, holding the last value.
- Data is captured at grant. A change of `req_data` after grant does not affect the transfer.
- Dropping `req` mid-transfer does not abort it. Both bytes are sent and `ack` still pulses.
- A requester re-asserting `req` in the cycle after `ack` is a new request and competes normally.

## Timing
- Reset values:
  - state=IDLE, phase=HDR, `ptr`=0, `grant_id`=0.
  - Data register = 0, `byteForTx`=0.
  - `txByteStart`=0, `ack`=0, `busy`=0.
- Reset takes effect on the next rising edge regardless of state, aborting any transfer with no `ack`.
  - A byte already started in the transmitter completes on its own.
  - The next START waits for `txReady`=1.
- Latency: `req` sampled high in IDLE at edge k → START in cycle k+1. With `txReady`=1, `txByteStart` pulses in cycle k+1.
- Minimum cost per transfer: 1 (IDLE) + 2×(1 START + ≥1 WAIT_ACCEPT + ≥1 WAIT_DONE) + 1 (ACK) cycles, plus the two UART byte times.
- There is always at least one IDLE cycle between an ACK and the next grant.
- At most one `txByteStart` pulse per byte. No pulse while `txReady`=0.
- Simultaneous requests are resolved only in IDLE. The pointer guarantees each pending requester is served within NUM_REQ grants.

## Test plan
- **Single request.** Transmitter model: `txReady` drops 1 cycle after start and returns 20 cycles later. Stimulus: `req`=4'b0100, data 8'h5A.
  - `byteForTx` sequence 8'hF2 then 8'h5A, two `txByteStart` pulses.
  - `ack`=4'b0100 for one cycle after the second byte.
  - `busy` falls the cycle after `ack`.
- **All four requests held from reset.** Grant order 0,1,2,3 with headers F0,F1,F2,F3, four acks in that order. Re-asserted after the last ack, the order is 0,1,2,3 again.
- **Fairness.** `req[0]` re-asserted immediately after every ack, `req[2]` held constantly. Grant order alternates 0,2,0,2…; `req[0]` never receives two consecutive grants.
- **Busy transmitter.** `txReady` held low for 50 cycles when the grant occurs. Arbiter stays in START with `txByteStart`=0 throughout, then pulses exactly once in the cycle `txReady` rises.
- **Request and data withdrawn.** `req[1]` and `req_data` changed to 8'h00 during the header byte. Data byte sent is the originally latched value and `ack[1]` still pulses.
- **Reset mid-transfer.** `rst` asserted during the data-byte WAIT_DONE.
  - Next cycle: `busy`=0, `ack`=0, `ptr`=0.
  - With `req`=4'b1000 afterwards, the first start waits until `txReady`=1, then header F3 is sent.
